serial_paralelo: RTL and testbench
==================================

Name: serial_paralelo

Overview:
- Receive-side deserializer; sits directly downstream of paralelo_serial and consumes its 1-bit data_out stream.
- Hunts for the 0xBC comma to find byte alignment, and declares link active after BC_COUNT consecutive aligned commas.
- Once active, reassembles bytes (MSB first) and emits each non-comma byte with a one-cycle valid strobe.
- Single-clock design: clk_32f is the bit clock, and the byte strobe is derived internally (no clk_4f input).

Parameters:
- COMMA, 8'hBC, idle/sync symbol inserted by the transmitter when valid_in is low.
- BC_COUNT, 4, consecutive aligned commas required to enter ACTIVE (legal range 1..15).

Ports:
- clk_32f  input  1  bit clock; every state element is clocked on its rising edge.
- reset  input  1  synchronous, active-low reset; 0 at a rising edge of clk_32f resets the block.
- data_in  input  1  serial bit stream, MSB of each byte first; sampled every rising edge.
- data_out  output  8  last received non-comma byte.
- valid_out  output  1  one-cycle pulse marking a new data_out.
- active  output  1  high while byte-aligned and synchronized.

Behaviour:
- Reset (reset==0 at an edge) clears state to HUNT, shift reg sr[6:0]=0, bit_cnt=0, bc_cnt=0, data_out=8'h00, valid_out=0, active=0.
- Reset has priority over every other event, including mid-byte and in ACTIVE. After reset a fresh hunt and BC_COUNT commas are required.
- Every non-reset edge: cand={sr[6:0],data_in}; then sr<=cand[6:0].
- HUNT:
  - cand checked every edge.
  - cand==COMMA -> bit_cnt<=0, bc_cnt<=1, go SYNC. If BC_COUNT==1, go directly to ACTIVE instead.
  - Otherwise stay in HUNT.
  - active=0, valid_out=0.
- SYNC:
  - bit_cnt increments every edge, wrapping 7->0.
  - On an edge where bit_cnt==7 (byte boundary) and cand==COMMA: bc_cnt<=bc_cnt+1. If bc_cnt+1==BC_COUNT -> ACTIVE, with active<=1 on that same edge.
  - On a boundary edge with cand!=COMMA: back to HUNT, bc_cnt<=0. The misaligned or data byte is discarded and never output.
  - valid_out=0 throughout SYNC.
- ACTIVE:
  - bit_cnt keeps wrapping.
  - At each boundary edge with cand!=COMMA: data_out<=cand, valid_out<=1.
  - At a boundary edge with cand==COMMA: valid_out<=0 and data_out holds.
  - All non-boundary edges: valid_out<=0.
  - active stays 1 until reset; there is no loss-of-sync detection in this revision.
- Latency: data_out/valid_out change on the same edge that samples bit 0 (LSB) of the byte. valid_out is high for exactly one clk_32f cycle. Consecutive pulses are at least 8 cycles apart.
- Alignment in HUNT is a bit-granular search, so any bit offset of the incoming stream is accepted. A comma pattern straddling two data bytes in HUNT can cause false alignment; the subsequent SYNC checks reject it.
- bc_cnt saturates conceptually at BC_COUNT; width is 4 bits.

Decomposition:
- Shared header/package, also used by paralelo_serial: COMMA (8'hBC), BC_COUNT default (4), and state encodings (HUNT=2'd0, SYNC=2'd1, ACTIVE=2'd2).
- No sub-module required; the comma compare is one equality on cand.
- Verification follows the usual pattern: bench + probador_serial_paralelo driving clk_32f/reset/data_in and checking the RTL and the Yosys-synthesized serial_paralelo_synth side by side.

Test Plan:
- Reset check: reset=0 for 3 edges while data_in toggles -> data_out=00, valid_out=0, active=0 throughout.
- Basic sync: 4×0xBC then 0x5A, MSB first, from the first post-reset bit -> active rises on the edge sampling bit 0 of the 4th BC (edge 32). valid_out pulses on edge 40 with data_out=5A; no earlier pulse.
- Misaligned start: bits 1,0,1 then 4×0xBC then 0x33 -> active at edge 35, single pulse at edge 43 with data_out=33.
- Broken sync: BC,BC,0x12,BC,BC,BC,BC,0xA5 -> active=0 until the edge sampling the last bit of the 7th byte. 0x12 never appears on data_out; the only pulse carries A5.
- Idle insertion in ACTIVE: after sync send 0x01,0xBC,0x02 -> pulses 16 cycles apart with values 01 then 02. data_out holds 01 during the BC byte; no pulse for BC.
- Reset mid-ACTIVE: assert reset for 1 edge in the middle of a byte -> next edge all outputs 0. Following data bytes produce no pulses until 4 fresh BCs are received.

Source files
------------

// File: rtl/serial_paralelo_pkg.sv
// Shared constants and state encoding for the serial link (paralelo_serial / serial_paralelo).
package serial_paralelo_pkg;

    localparam logic [7:0]  COMMA_SYM        = 8'hBC;
    localparam int unsigned BC_COUNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StSync   = 2'd1,
        StActive = 2'd2
    } state_e;

endpackage

// File: rtl/serial_paralelo_if.sv
// Serial-in / byte-out signal bundle of the receive deserializer.
interface serial_paralelo_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

endinterface

// File: rtl/serial_paralelo.sv
// Receive deserializer: comma hunt, BC_COUNT-comma synchronization, MSB-first byte reassembly.
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0]  COMMA    = COMMA_SYM,
    parameter int unsigned BC_COUNT = BC_COUNT_DEFAULT
) (
    input logic               clk_32f,
    input logic               reset,
    serial_paralelo_if.slave  bus
);

    state_e     state_q, state_d;
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    logic [7:0] cand;
    logic       is_comma;
    logic       boundary;

    assign cand     = {sr_q, bus.data_in};
    assign is_comma = (cand == COMMA);
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        unique case (state_q)
            StHunt: begin
                // Bit-granular search; the comma just seen defines the byte phase.
                bit_cnt_d = '0;
                if (is_comma) begin
                    bc_cnt_d = 4'd1;
                    state_d  = (BC_COUNT == 1) ? StActive : StSync;
                end
            end
            StSync: begin
                if (boundary) begin
                    if (is_comma) begin
                        bc_cnt_d = bc_cnt_q + 4'd1;
                        if (({1'b0, bc_cnt_q} + 5'd1) == 5'(BC_COUNT)) begin
                            state_d = StActive;
                        end
                    end else begin
                        bc_cnt_d = '0;
                        state_d  = StHunt;
                    end
                end
            end
            StActive: begin
                if (boundary && !is_comma) begin
                    data_d  = cand;
                    valid_d = 1'b1;
                end
            end
            default: state_d = StHunt;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q   <= StHunt;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= cand[6:0];
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = (state_q == StActive);

endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: directed vector table plus randomized streams vs a model.
module tb_serial_paralelo;

    localparam logic [7:0] BC   = 8'hBC;
    localparam int         BCN  = 4;
    localparam int         MAXN = 1024;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;

    serial_paralelo_if bus ();

    serial_paralelo #(
        .COMMA    (BC),
        .BC_COUNT (BCN)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int checks   = 0;
    int failures = 0;

    logic       stim  [MAXN];
    int         n;
    logic       exp_v [MAXN];
    logic       exp_a [MAXN];
    logic [7:0] exp_d [MAXN];

    int         first_act, first_pulse, last_pulse, npulse;
    logic [7:0] first_data, last_data;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic b);
        bus.data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            stim[n] = b[i];
            n++;
        end
    endtask

    // Byte formed by the 8 most recent bits ending at index t (zero before the stream start).
    function automatic logic [7:0] byte_at(input int t);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = t - 7 + i;
            b = {b[6:0], (idx >= 0) ? stim[idx] : 1'b0};
        end
        return b;
    endfunction

    // Position-based reference: locate the first run of BCN aligned commas, then every
    // 8th bit after it is a byte boundary where non-comma bytes are emitted.
    task automatic build_expect();
        int t, k, cnt, act;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            exp_v[i] = 1'b0;
            exp_a[i] = 1'b0;
            exp_d[i] = 8'h00;
        end
        t   = 0;
        act = -1;
        while (t < n && act < 0) begin
            if (byte_at(t) != BC) begin
                t++;
            end else begin
                cnt = 1;
                k   = t;
                while (cnt < BCN && k + 8 < n && byte_at(k + 8) == BC) begin
                    k += 8;
                    cnt++;
                end
                if (cnt == BCN) act = k;
                else t = k + 9;
            end
        end
        if (act >= 0) begin
            for (int i = act; i < n; i++) exp_a[i] = 1'b1;
            for (int i = act + 8; i < n; i += 8) begin
                if (byte_at(i) != BC) exp_v[i] = 1'b1;
            end
        end
        d = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (exp_v[i]) d = byte_at(i);
            exp_d[i] = d;
        end
    endtask

    task automatic run_stream(input string name);
        build_expect();
        first_act   = -1;
        first_pulse = -1;
        last_pulse  = -1;
        npulse      = 0;
        first_data  = 8'h00;
        last_data   = 8'h00;
        for (int t = 0; t < n; t++) begin
            step(stim[t]);
            check({name, ".valid"}, int'(bus.valid_out), int'(exp_v[t]));
            check({name, ".active"}, int'(bus.active), int'(exp_a[t]));
            check({name, ".data"}, int'(bus.data_out), int'(exp_d[t]));
            if (bus.active && first_act < 0) first_act = t + 1;
            if (bus.valid_out) begin
                if (first_pulse < 0) begin
                    first_pulse = t + 1;
                    first_data  = bus.data_out;
                end
                last_pulse = t + 1;
                last_data  = bus.data_out;
                npulse++;
            end
        end
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b0;
        for (int i = 0; i < edges; i++) begin
            step(logic'(i[0]));
            check("rst.valid", int'(bus.valid_out), 0);
            check("rst.active", int'(bus.active), 0);
            check("rst.data", int'(bus.data_out), 0);
        end
        reset = 1'b1;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  pre;
        int          pre_len;
        logic [79:0] bytes;
        int          nbytes;
        int          act_edge;
        int          npulses;
        int          p1_edge;
        logic [7:0]  p1_data;
        int          p2_edge;
        logic [7:0]  p2_data;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{"basic", 3'b000, 0, {BC, BC, BC, BC, 8'h5A, 40'h0}, 5,
                    32, 1, 40, 8'h5A, 40, 8'h5A};
        vecs[1] = '{"misalign", 3'b101, 3, {BC, BC, BC, BC, 8'h33, 40'h0}, 5,
                    35, 1, 43, 8'h33, 43, 8'h33};
        vecs[2] = '{"broken", 3'b000, 0,
                    {BC, BC, 8'h12, BC, BC, BC, BC, 8'hA5, 16'h0}, 8,
                    56, 1, 64, 8'hA5, 64, 8'hA5};
        vecs[3] = '{"idle", 3'b000, 0, {BC, BC, BC, BC, 8'h01, BC, 8'h02, 24'h0}, 7,
                    32, 2, 40, 8'h01, 56, 8'h02};

        bus.data_in = 1'b0;
        reset       = 1'b0;
        do_reset(3);

        foreach (vecs[v]) begin
            do_reset(2);
            n = 0;
            for (int i = vecs[v].pre_len - 1; i >= 0; i--) begin
                stim[n] = vecs[v].pre[i];
                n++;
            end
            for (int i = 0; i < vecs[v].nbytes; i++) push_byte(vecs[v].bytes[79 - 8 * i -: 8]);
            run_stream(vecs[v].name);
            check({vecs[v].name, ".act_edge"}, first_act, vecs[v].act_edge);
            check({vecs[v].name, ".npulses"}, npulse, vecs[v].npulses);
            check({vecs[v].name, ".p1_edge"}, first_pulse, vecs[v].p1_edge);
            check({vecs[v].name, ".p1_data"}, int'(first_data), int'(vecs[v].p1_data));
            check({vecs[v].name, ".p2_edge"}, last_pulse, vecs[v].p2_edge);
            check({vecs[v].name, ".p2_data"}, int'(last_data), int'(vecs[v].p2_data));
        end

        // Reset in the middle of a byte while active.
        do_reset(2);
        n = 0;
        for (int i = 0; i < 4; i++) push_byte(BC);
        push_byte(8'h5A);
        run_stream("midrst.pre");
        step(1'b1);
        step(1'b0);
        step(1'b1);
        check("midrst.still_active", int'(bus.active), 1);
        do_reset(1);
        n = 0;
        push_byte(8'h77);
        push_byte(8'h88);
        for (int i = 0; i < 4; i++) push_byte(BC);
        push_byte(8'h99);
        run_stream("midrst.post");
        check("midrst.act_edge", first_act, 48);
        check("midrst.npulses", npulse, 1);
        check("midrst.p1_data", int'(first_data), 8'h99);
        check("midrst.p1_edge", first_pulse, 56);

        // Randomized streams with random bit offset and a comma-heavy byte mix.
        for (int it = 0; it < 25; it++) begin
            int plen;
            do_reset(2);
            n    = 0;
            plen = int'($urandom_range(0, 7));
            for (int i = 0; i < plen; i++) begin
                stim[n] = logic'($urandom_range(0, 1));
                n++;
            end
            for (int i = 0; i < 14; i++) begin
                logic [7:0] b;
                b = ($urandom_range(0, 99) < 55) ? BC : 8'($urandom);
                push_byte(b);
            end
            run_stream("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
